// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the unified memory port arbiter
package mem_arb_pkg;

    localparam int DEFAULT_ADDR_W = 32;
    localparam int DEFAULT_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_FETCH = 2'd2
    } arb_state_t;

    // Encoding of the requester that completed the most recent access
    localparam logic GRANT_FETCH = 1'b0;
    localparam logic GRANT_DATA  = 1'b1;

endpackage

// File: rtl/fetch_line_buffer.sv
// rtl/fetch_line_buffer.sv - one-entry fetch buffer (tag, word, valid); built only with FETCH_BUFFER_EN
`ifdef FETCH_BUFFER_EN
module fetch_line_buffer
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              lookupEn,
    input  logic [ADDR_W-1:0] lookupAddr,
    output logic              hit,
    output logic [DATA_W-1:0] hitData,
    input  logic              fillEn,
    input  logic [ADDR_W-1:0] fillAddr,
    input  logic [DATA_W-1:0] fillData,
    input  logic              invEn,
    input  logic [ADDR_W-1:0] invAddr
);

    logic              entryValid;
    logic [ADDR_W-1:0] entryTag;
    logic [DATA_W-1:0] entryWord;

    // Fill on every fetch completion; a store to the buffered address kills the entry
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            entryValid <= 1'b0;
            entryTag   <= '0;
            entryWord  <= '0;
        end else if (fillEn) begin
            entryValid <= 1'b1;
            entryTag   <= fillAddr;
            entryWord  <= fillData;
        end else if (invEn && entryValid && (invAddr == entryTag)) begin
            entryValid <= 1'b0;
        end
    end

    // Tag compare is combinational so a hit completes the fetch in the same cycle
    always_comb begin
        hit     = lookupEn && entryValid && (lookupAddr == entryTag);
        hitData = entryWord;
    end

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for the unified memory port; FETCH_BUFFER_EN adds a one-entry fetch buffer
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              FetchReqF,
    input  logic [ADDR_W-1:0] FetchAddrF,
    output logic [DATA_W-1:0] FetchDataF,
    output logic              FetchStallF,
    input  logic              DataReqM,
    input  logic              DataWeM,
    input  logic [ADDR_W-1:0] DataAddrM,
    input  logic [DATA_W-1:0] DataWDataM,
    output logic [DATA_W-1:0] DataRDataM,
    output logic              DataStallM,
    output logic              MemReq,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    input  logic [DATA_W-1:0] MemRData,
    input  logic              MemAck
);

    arb_state_t        state;
    arb_state_t        nextState;
    logic              lastGrant;
    logic              grantData;
    logic              grantFetch;
    logic              weReg;
    logic [ADDR_W-1:0] addrReg;
    logic [DATA_W-1:0] wdataReg;
    logic [DATA_W-1:0] fetchHold;
    logic [DATA_W-1:0] dataHold;
    logic              fetchDone;
    logic              dataDone;
    logic              fetchPend;
    logic              bufHit;
    logic [DATA_W-1:0] bufData;

    assign fetchDone = (state == ST_FETCH) && MemAck;
    assign dataDone  = (state == ST_DATA) && MemAck;

`ifdef FETCH_BUFFER_EN
    fetch_line_buffer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fetch_line_buffer (
        .Clk        (Clk),
        .Reset      (Reset),
        .lookupEn   ((state == ST_IDLE) || (state == ST_DATA)),
        .lookupAddr (FetchAddrF),
        .hit        (bufHit),
        .hitData    (bufData),
        .fillEn     (fetchDone),
        .fillAddr   (addrReg),
        .fillData   (MemRData),
        .invEn      (dataDone && weReg),
        .invAddr    (addrReg)
    );
`else
    assign bufHit  = 1'b0;
    assign bufData = '0;
`endif

    // A fetch served from the buffer never competes for the memory port
    assign fetchPend = FetchReqF && !(FetchReqF && bufHit);

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= ST_IDLE;
        else       state <= nextState;
    end

    // Next-state: IDLE picks by priority/fairness; a completion chains to the other requester
    always_comb begin
        grantData  = 1'b0;
        grantFetch = 1'b0;
        case (state)
            ST_IDLE: begin
                if (DataReqM && (!fetchPend || lastGrant == GRANT_FETCH)) grantData = 1'b1;
                else if (fetchPend)                                       grantFetch = 1'b1;
            end
            ST_DATA: begin
                // The completing data request is still asserted this cycle, so only fetch may chain
                if (MemAck && fetchPend) grantFetch = 1'b1;
            end
            ST_FETCH: begin
                if (MemAck && DataReqM) grantData = 1'b1;
            end
            default: ;
        endcase
        if (grantData)                     nextState = ST_DATA;
        else if (grantFetch)               nextState = ST_FETCH;
        else if (state == ST_IDLE)         nextState = ST_IDLE;
        else if (MemAck)                   nextState = ST_IDLE;
        else                               nextState = state;
    end

    // Outputs: stalls, returned data and the memory-side request
    always_comb begin
        MemReq      = (state != ST_IDLE);
        MemWe       = weReg && (state == ST_DATA);
        MemAddr     = addrReg;
        MemWData    = wdataReg;
        FetchStallF = FetchReqF && !(fetchDone || bufHit);
        DataStallM  = DataReqM && !dataDone;
        if (fetchDone)   FetchDataF = MemRData;
        else if (bufHit) FetchDataF = bufData;
        else             FetchDataF = fetchHold;
        DataRDataM  = dataDone ? MemRData : dataHold;
    end

    // Latch the granted access; hold registers skip flushed completions; track fairness
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            lastGrant <= GRANT_FETCH;
            weReg     <= 1'b0;
            addrReg   <= '0;
            wdataReg  <= '0;
            fetchHold <= '0;
            dataHold  <= '0;
        end else begin
            if (fetchDone) lastGrant <= GRANT_FETCH;
            if (dataDone)  lastGrant <= GRANT_DATA;
            if (fetchDone && FetchReqF) fetchHold <= MemRData;
            if (dataDone && DataReqM)   dataHold  <= MemRData;
            if (grantData) begin
                addrReg  <= DataAddrM;
                weReg    <= DataWeM;
                wdataReg <= DataWDataM;
            end else if (grantFetch) begin
                addrReg <= FetchAddrF;
                weReg   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        FetchReqF;
    logic [31:0] FetchAddrF;
    logic [31:0] FetchDataF;
    logic        FetchStallF;
    logic        DataReqM;
    logic        DataWeM;
    logic [31:0] DataAddrM;
    logic [31:0] DataWDataM;
    logic [31:0] DataRDataM;
    logic        DataStallM;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [31:0] MemRData;
    logic        MemAck;

    int nChecks = 0;
    int nPass   = 0;
    int stallCnt;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .FetchReqF   (FetchReqF),
        .FetchAddrF  (FetchAddrF),
        .FetchDataF  (FetchDataF),
        .FetchStallF (FetchStallF),
        .DataReqM    (DataReqM),
        .DataWeM     (DataWeM),
        .DataAddrM   (DataAddrM),
        .DataWDataM  (DataWDataM),
        .DataRDataM  (DataRDataM),
        .DataStallM  (DataStallM),
        .MemReq      (MemReq),
        .MemWe       (MemWe),
        .MemAddr     (MemAddr),
        .MemWData    (MemWData),
        .MemRData    (MemRData),
        .MemAck      (MemAck)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b1; FetchReqF = 1'b1; FetchAddrF = 32'h0;
        DataReqM = 1'b0; DataWeM = 1'b0; DataAddrM = 32'h0; DataWDataM = 32'h0;
        MemRData = 32'h0; MemAck = 1'b0;
        step(); step();
        #1;
        check("rst_memreq", {31'b0, MemReq}, 32'd0);
        check("rst_memwe", {31'b0, MemWe}, 32'd0);
        check("rst_memaddr", MemAddr, 32'h0);
        check("rst_memwdata", MemWData, 32'h0);
        check("rst_fetchdata", FetchDataF, 32'h0);
        check("rst_datardata", DataRDataM, 32'h0);
        check("rst_fstall", {31'b0, FetchStallF}, 32'd1);

        // Single fetch, zero wait states
        step(); Reset = 1'b0; FetchReqF = 1'b1; FetchAddrF = 32'h100; #1;
        check("t1_req_n", {31'b0, MemReq}, 32'd0);
        check("t1_stall_n", {31'b0, FetchStallF}, 32'd1);
        step(); MemAck = 1'b1; MemRData = 32'hE3A01005; #1;
        check("t1_memreq", {31'b0, MemReq}, 32'd1);
        check("t1_memaddr", MemAddr, 32'h100);
        check("t1_memwe", {31'b0, MemWe}, 32'd0);
        check("t1_stall", {31'b0, FetchStallF}, 32'd0);
        check("t1_data", FetchDataF, 32'hE3A01005);
        step(); FetchReqF = 1'b0; MemAck = 1'b0; MemRData = 32'h0; #1;
        check("t1_req_drop", {31'b0, MemReq}, 32'd0);
        check("t1_hold", FetchDataF, 32'hE3A01005);

        // Contention: data first, fetch chained, two wait cycles each
        DataReqM = 1'b1; DataWeM = 1'b0; DataAddrM = 32'h300;
        FetchReqF = 1'b1; FetchAddrF = 32'h104; #1;
        check("t2_idle_fstall", {31'b0, FetchStallF}, 32'd1);
        stallCnt = 0;
        step();
        check("t2_data_first", MemAddr, 32'h300);
        for (int i = 0; i < 3; i++) begin
            MemAck = (i == 2); MemRData = 32'h11111111; #1;
            if (FetchStallF) stallCnt++;
            check("t2_dstall", {31'b0, DataStallM}, (i == 2) ? 32'd0 : 32'd1);
            if (i == 2) check("t2_drdata", DataRDataM, 32'h11111111);
            step();
        end
        DataReqM = 1'b0; MemAck = 1'b0; #1;
        check("t2_chain_req", {31'b0, MemReq}, 32'd1);
        check("t2_chain_addr", MemAddr, 32'h104);
        for (int i = 0; i < 3; i++) begin
            MemAck = (i == 2); MemRData = 32'h22222222; #1;
            if (FetchStallF) stallCnt++;
            if (i == 2) check("t2_fdata", FetchDataF, 32'h22222222);
            step();
        end
        FetchReqF = 1'b0; MemAck = 1'b0; #1;
        check("t2_fstall_cycles", stallCnt, 32'd5);
        check("t2_idle", {31'b0, MemReq}, 32'd0);
        check("t2_dhold", DataRDataM, 32'h11111111);

        // Lone load so the fairness bit points at data
        DataReqM = 1'b1; DataWeM = 1'b0; DataAddrM = 32'h400;
        step(); MemAck = 1'b1; MemRData = 32'h33333333; #1;
        check("t3_load", DataRDataM, 32'h33333333);
        step(); DataReqM = 1'b0; MemAck = 1'b0; #1;

        // Store and fetch together with LastGrant=DATA: fetch goes first
        DataReqM = 1'b1; DataWeM = 1'b1; DataAddrM = 32'h200; DataWDataM = 32'hDEADBEEF;
        FetchReqF = 1'b1; FetchAddrF = 32'h108;
        step();
        check("t3_fetch_first", MemAddr, 32'h108);
        check("t3_fetch_we", {31'b0, MemWe}, 32'd0);
        MemAck = 1'b1; MemRData = 32'h44444444; #1;
        check("t3_fdata", FetchDataF, 32'h44444444);
        step(); FetchReqF = 1'b0; MemAck = 1'b0; #1;
        check("t3_st_addr", MemAddr, 32'h200);
        check("t3_st_we", {31'b0, MemWe}, 32'd1);
        check("t3_st_wdata", MemWData, 32'hDEADBEEF);
        check("t3_st_stall", {31'b0, DataStallM}, 32'd1);
        MemAck = 1'b1; #1;
        check("t3_st_done", {31'b0, DataStallM}, 32'd0);
        step(); DataReqM = 1'b0; DataWeM = 1'b0; MemAck = 1'b0; #1;
        check("t3_idle", {31'b0, MemReq}, 32'd0);

        // Fetch flushed mid-access: transaction completes, hold untouched
        FetchReqF = 1'b1; FetchAddrF = 32'h10C;
        step(); FetchReqF = 1'b0; #1;
        check("t4_req", {31'b0, MemReq}, 32'd1);
        step();
        check("t4_wait", {31'b0, MemReq}, 32'd1);
        MemAck = 1'b1; MemRData = 32'hBAD0BAD0;
        step(); MemAck = 1'b0; #1;
        check("t4_idle", {31'b0, MemReq}, 32'd0);
        check("t4_hold", FetchDataF, 32'h44444444);

        // Asynchronous reset while a store is outstanding
        DataReqM = 1'b1; DataWeM = 1'b1; DataAddrM = 32'h500; DataWDataM = 32'h55;
        step();
        check("t5_req", {31'b0, MemReq}, 32'd1);
        check("t5_addr", MemAddr, 32'h500);
        #1 Reset = 1'b1;
        #1;
        check("t5_rst_req", {31'b0, MemReq}, 32'd0);
        check("t5_rst_addr", MemAddr, 32'h0);
        check("t5_rst_wdata", MemWData, 32'h0);
        check("t5_rst_fhold", FetchDataF, 32'h0);
        check("t5_rst_dhold", DataRDataM, 32'h0);
        check("t5_rst_dstall", {31'b0, DataStallM}, 32'd1);
        step(); Reset = 1'b0; DataReqM = 1'b0; DataWeM = 1'b0; #1;

`ifdef FETCH_BUFFER_EN
        // Fill buffer, refetch hits, store invalidates
        FetchReqF = 1'b1; FetchAddrF = 32'h100;
        step(); MemAck = 1'b1; MemRData = 32'hE3A01005;
        step(); FetchReqF = 1'b0; MemAck = 1'b0; #1;
        FetchReqF = 1'b1; FetchAddrF = 32'h100; #1;
        check("t6_hit_stall", {31'b0, FetchStallF}, 32'd0);
        check("t6_hit_data", FetchDataF, 32'hE3A01005);
        step();
        check("t6_hit_nomem", {31'b0, MemReq}, 32'd0);
        FetchReqF = 1'b0;
        DataReqM = 1'b1; DataWeM = 1'b1; DataAddrM = 32'h100; DataWDataM = 32'h1;
        step(); MemAck = 1'b1;
        step(); DataReqM = 1'b0; DataWeM = 1'b0; MemAck = 1'b0; #1;
        FetchReqF = 1'b1; FetchAddrF = 32'h100; #1;
        check("t6_inv_stall", {31'b0, FetchStallF}, 32'd1);
        step();
        check("t6_inv_mem", {31'b0, MemReq}, 32'd1);
        MemAck = 1'b1;
        step(); FetchReqF = 1'b0; MemAck = 1'b0; #1;
`endif

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
